// File: rtl/t3_match_collector.sv
// ============================================================================
// Module      : t3_match_collector
// Description : Serialises multi-lane T3 hit vectors into a result FIFO.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module t3_match_collector #(
  parameter int NCH        = 2,
  parameter int LANES      = 16,
  parameter int IDX_W      = 9,
  parameter int POS_W      = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic [NCH*2*LANES-1:0]     cmp_vec,
  input  logic [NCH*LANES*IDX_W-1:0] addr_a,
  input  logic [NCH*LANES*IDX_W-1:0] addr_b,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_ch,
  output logic [LANE_W-1:0]          out_lane,
  output logic                       out_port,
  output logic [IDX_W-1:0]           out_index,
  output logic [POS_W-1:0]           out_pos,
  output logic [31:0]                match_cnt,
  output logic [15:0]                drop_cnt,
  output logic                       overflow
);

  localparam int NB = NCH * 2 * LANES;
  localparam int NL = NCH * LANES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CH_W + LANE_W + 1 + IDX_W + POS_W;

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t              state;
  logic [NB-1:0]       snap_vec;
  logic [NL*IDX_W-1:0] snap_a;
  logic [NL*IDX_W-1:0] snap_b;
  logic [POS_W-1:0]    snap_pos;
  logic [POS_W-1:0]    pos_cnt;

  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [EW-1:0]       last_q;

  // Lowest set bit of the snapshot; loop runs high-to-low so the lowest wins.
  logic [NB-1:0]       sel_mask;
  logic [CH_W-1:0]     sel_ch;
  logic [LANE_W-1:0]   sel_lane;
  logic                sel_port;
  logic [IDX_W-1:0]    sel_idx;

  always_comb begin
    sel_mask = '0;
    sel_ch   = '0;
    sel_lane = '0;
    sel_port = 1'b0;
    sel_idx  = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (snap_vec[k]) begin
        sel_mask    = '0;
        sel_mask[k] = 1'b1;
        sel_ch      = CH_W'(k / (2 * LANES));
        sel_lane    = LANE_W'((k / 2) % LANES);
        sel_port    = (k % 2) == 1;
        sel_idx     = ((k % 2) == 1) ? snap_b[(k/2)*IDX_W +: IDX_W]
                                     : snap_a[(k/2)*IDX_W +: IDX_W];
      end
    end
  end

  logic [AW:0]   fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [NB-1:0] rest;
  logic          last;
  logic          take;
  logic          hit;
  logic          load;
  logic          drop;
  logic [EW-1:0] push_ent;
  logic [EW-1:0] head;
  logic [EW-1:0] out_data;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign push       = (state == SCAN) && !fifo_full;
  assign pop        = !fifo_empty && out_ready;
  assign rest       = snap_vec & ~sel_mask;
  assign last       = (rest == '0);
  assign take       = enable && in_valid;
  assign hit        = take && (cmp_vec != '0);
  // Reloading on the last-bit push keeps consecutive beats bubble-free.
  assign load       = hit && ((state == IDLE) || (push && last));
  assign drop       = hit && (state == SCAN) && !(push && last);
  assign push_ent   = {sel_ch, sel_lane, sel_port, sel_idx, snap_pos};
  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_data   = fifo_empty ? last_q : head;
  assign out_valid  = !fifo_empty;
  assign {out_ch, out_lane, out_port, out_index, out_pos} = out_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      snap_vec <= '0;
      snap_a   <= '0;
      snap_b   <= '0;
      snap_pos <= '0;
      pos_cnt  <= '0;
    end else begin
      if (take) begin
        pos_cnt <= pos_cnt + 1'b1;
      end
      if (load) begin
        snap_vec <= cmp_vec;
        snap_a   <= addr_a;
        snap_b   <= addr_b;
        snap_pos <= pos_cnt;
        state    <= SCAN;
      end else if (push) begin
        snap_vec <= rest;
        if (last) begin
          state <= IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_ent;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= head;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      match_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        match_cnt <= match_cnt + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_t3_match_collector.sv
// ============================================================================
// Module      : tb_t3_match_collector
// Description : Scoreboard bench for t3_match_collector with directed vectors.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_t3_match_collector;

  localparam int NCH   = 2;
  localparam int LANES = 16;
  localparam int IDX_W = 9;
  localparam int POS_W = 16;
  localparam int EW    = 1 + 4 + 1 + IDX_W + POS_W;

  logic                       clk;
  logic                       rst;
  logic                       enable;
  logic                       in_valid;
  logic [NCH*2*LANES-1:0]     cmp_vec;
  logic [NCH*LANES*IDX_W-1:0] addr_a;
  logic [NCH*LANES*IDX_W-1:0] addr_b;
  logic                       clear;
  logic                       out_valid;
  logic                       out_ready;
  logic [0:0]                 out_ch;
  logic [3:0]                 out_lane;
  logic                       out_port;
  logic [IDX_W-1:0]           out_index;
  logic [POS_W-1:0]           out_pos;
  logic [31:0]                match_cnt;
  logic [15:0]                drop_cnt;
  logic                       overflow;

  t3_match_collector dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .cmp_vec   (cmp_vec),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_lane  (out_lane),
    .out_port  (out_port),
    .out_index (out_index),
    .out_pos   (out_pos),
    .match_cnt (match_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int tb_pos = 0;
  logic [EW-1:0] exp_q [$];

  logic [NCH*2*LANES-1:0]     stage_vec;
  logic [NCH*LANES*IDX_W-1:0] stage_a;
  logic [NCH*LANES*IDX_W-1:0] stage_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_ent(input int c, input int l, input int p, input int idx, input int pos);
    exp_q.push_back({1'(c), 4'(l), 1'(p), 9'(idx), 16'(pos)});
  endtask

  task automatic add_hit(input int c, input int l, input int p, input int idx);
    stage_vec[c*2*LANES + 2*l + p] = 1'b1;
    if (p == 0) stage_a[(c*LANES + l)*IDX_W +: IDX_W] = 9'(idx);
    else        stage_b[(c*LANES + l)*IDX_W +: IDX_W] = 9'(idx);
  endtask

  // Presents the staged beat for one cycle; caller sits just after a rising edge.
  task automatic send_beat(input logic en);
    enable    = en;
    in_valid  = 1'b1;
    cmp_vec   = stage_vec;
    addr_a    = stage_a;
    addr_b    = stage_b;
    @(posedge clk); #1;
    enable    = 1'b1;
    in_valid  = 1'b0;
    cmp_vec   = '0;
    stage_vec = '0;
    stage_a   = '0;
    stage_b   = '0;
    if (en) tb_pos++;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      logic [EW-1:0] got;
      logic [EW-1:0] want;
      got = {out_ch, out_lane, out_port, out_index, out_pos};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL result: unexpected entry ch%0d lane%0d port%0d idx%0d pos%0d",
                 out_ch, out_lane, out_port, out_index, out_pos);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL result: got ch%0d lane%0d port%0d idx%0d pos%0d, expected ch%0d lane%0d port%0d idx%0d pos%0d",
                   got[30], got[29:26], got[25], got[24:16], got[15:0],
                   want[30], want[29:26], want[25], want[24:16], want[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    in_valid  = 1'b0;
    cmp_vec   = '0;
    addr_a    = '0;
    addr_b    = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    stage_vec = '0;
    stage_a   = '0;
    stage_b   = '0;
    #1 rst = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_index", 32'(out_index), 0);
    check("reset out_pos",   32'(out_pos), 0);
    check("reset match_cnt", match_cnt, 0);
    check("reset overflow",  32'(overflow), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single hit at beat 5 with exact latency.
    repeat (5) send_beat(1'b1);
    add_hit(0, 3, 0, 300);
    expect_ent(0, 3, 0, 300, tb_pos);
    send_beat(1'b1);
    @(negedge clk);
    check("latency cycle1 out_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("latency cycle2 out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    wait_drain("single drain");
    check("single match_cnt", match_cnt, 1);

    // Multi-hit ordering across channels.
    add_hit(1, 0, 1, 17);
    add_hit(0, 15, 0, 42);
    expect_ent(0, 15, 0, 42, tb_pos);
    expect_ent(1, 0, 1, 17, tb_pos);
    send_beat(1'b1);
    wait_drain("multi drain");

    // Back-to-back beats.
    add_hit(0, 1, 1, 5);
    expect_ent(0, 1, 1, 5, tb_pos);
    send_beat(1'b1);
    add_hit(1, 7, 0, 77);
    expect_ent(1, 7, 0, 77, tb_pos);
    send_beat(1'b1);
    wait_drain("b2b drain");
    check("b2b drop_cnt", 32'(drop_cnt), 0);

    // Drop of a beat arriving mid-scan, then clear.
    add_hit(0, 0, 0, 1);
    add_hit(0, 0, 1, 2);
    add_hit(0, 1, 0, 3);
    expect_ent(0, 0, 0, 1, tb_pos);
    expect_ent(0, 0, 1, 2, tb_pos);
    expect_ent(0, 1, 0, 3, tb_pos);
    send_beat(1'b1);
    add_hit(1, 2, 0, 99);
    send_beat(1'b1);
    wait_drain("drop drain");
    check("drop drop_cnt", 32'(drop_cnt), 1);
    check("drop overflow", 32'(overflow), 1);
    check("pre-clear match_cnt", match_cnt, 8);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear drop_cnt", 32'(drop_cnt), 0);
    check("clear overflow", 32'(overflow), 0);
    check("clear match_cnt", match_cnt, 0);

    // Backpressure: 10 hits into an 8-deep FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      add_hit(0, i / 2, i % 2, 100 + i);
      expect_ent(0, i / 2, i % 2, 100 + i, tb_pos);
    end
    send_beat(1'b1);
    repeat (15) @(posedge clk);
    #1;
    check("stall out_valid", 32'(out_valid), 1);
    check("stall out_index", 32'(out_index), 100);
    check("stall match_cnt", match_cnt, 8);
    @(posedge clk); #1;
    check("stall stable index", 32'(out_index), 100);
    out_ready = 1'b1;
    wait_drain("bp drain");
    check("bp match_cnt", match_cnt, 10);

    // Asynchronous reset during a scan.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) add_hit(1, 10 + i, 0, 200 + i);
    send_beat(1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 0);
    check("async rst out_index", 32'(out_index), 0);
    exp_q.delete();
    tb_pos = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post-rst out_valid", 32'(out_valid), 0);
    check("post-rst match_cnt", match_cnt, 0);
    check("post-rst drop_cnt",  32'(drop_cnt), 0);
    out_ready = 1'b1;
    add_hit(0, 9, 1, 55);
    send_beat(1'b0);
    add_hit(0, 9, 1, 66);
    expect_ent(0, 9, 1, 66, 0);
    send_beat(1'b1);
    wait_drain("resume drain");
    check("resume match_cnt", match_cnt, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
